// File: rtl/neptune_pkg.sv
// neptune_pkg: shared FSM states, blank pattern and digit-select constants for the display sequencer
package neptune_pkg;
  typedef enum logic [1:0] {SHOW_NOTE, BLANK_TO_PROX, SHOW_PROX, BLANK_TO_NOTE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic DIGIT_NOTE = 1'b0;
  localparam logic DIGIT_PROX = 1'b1;
endpackage

// File: rtl/neptune_dwell_timer.sv
// neptune_dwell_timer: loadable down-counter (clk, rst, load, cfg in; zero out), load = 2^(DWELL_BASE+cfg)-1
module neptune_dwell_timer #(
  parameter int DWELL_BASE = 10,
  parameter int DWELL_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] cfg,
  output logic       zero
);
  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);
  logic [DWELL_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= (ONE << (DWELL_BASE + int'(cfg))) - ONE;
    else if (!zero) cnt <= cnt - ONE;
  assign zero = cnt == '0;
endmodule

// File: rtl/neptune_display_sequencer.sv
// neptune_display_sequencer: multiplexes note/prox digits onto one segment bus (segments, prox_select, frame_done out) with dead-time blanking and buffered commits
module neptune_display_sequencer
  import neptune_pkg::*;
#(
  parameter int DWELL_BASE = 10,
  parameter int DWELL_W = 18,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] clk_config,
  input  logic [6:0] note_segs,
  input  logic [6:0] prox_segs,
  input  logic       result_valid,
  input  logic       display_single_enable,
  input  logic       display_single_select,
  output logic [6:0] segments,
  output logic       prox_select,
  output logic       frame_done
);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
  state_t st, nxt;
  logic [DEAD_W-1:0] dead, dead_nxt;
  logic [6:0] pend_note, pend_prox, com_note, com_prox, in_note, in_prox;
  logic load, zero, commit, blank_prox, fd_nxt;
  neptune_dwell_timer #(.DWELL_BASE(DWELL_BASE), .DWELL_W(DWELL_W)) u_timer (
    .clk(clk), .rst(rst), .load(load), .cfg(clk_config), .zero(zero)
  );
  always_comb begin
    nxt = st;
    dead_nxt = dead;
    load = 1'b0;
    commit = 1'b0;
    blank_prox = display_single_enable ? display_single_select == DIGIT_PROX : st == BLANK_TO_PROX;
    case (st)
      SHOW_NOTE, SHOW_PROX: begin
        if (display_single_enable && (display_single_select == DIGIT_PROX) != (st == SHOW_PROX)) begin
          nxt = display_single_select == DIGIT_PROX ? BLANK_TO_PROX : BLANK_TO_NOTE;
          dead_nxt = DEAD_LOAD;
        end else if (zero && display_single_enable) begin
          load = 1'b1;
          commit = 1'b1;
        end else if (zero) begin
          nxt = st == SHOW_NOTE ? BLANK_TO_PROX : BLANK_TO_NOTE;
          dead_nxt = DEAD_LOAD;
        end
      end
      default: begin
        if (dead == DEAD_W'(1)) begin
          nxt = blank_prox ? SHOW_PROX : SHOW_NOTE;
          load = 1'b1;
          commit = !blank_prox;
        end else begin
          nxt = blank_prox ? BLANK_TO_PROX : BLANK_TO_NOTE;
          dead_nxt = dead - DEAD_W'(1);
        end
      end
    endcase
    in_note = commit ? (result_valid ? note_segs : pend_note) : com_note;
    in_prox = commit ? (result_valid ? prox_segs : pend_prox) : com_prox;
    fd_nxt = st == SHOW_PROX && zero && !display_single_enable;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= BLANK_TO_NOTE;
      dead <= DEAD_LOAD;
      pend_note <= SEG_BLANK;
      pend_prox <= SEG_BLANK;
      com_note <= SEG_BLANK;
      com_prox <= SEG_BLANK;
      segments <= SEG_BLANK;
      prox_select <= DIGIT_NOTE;
      frame_done <= 1'b0;
    end else begin
      st <= nxt;
      dead <= dead_nxt;
      if (result_valid) begin
        pend_note <= note_segs;
        pend_prox <= prox_segs;
      end
      com_note <= in_note;
      com_prox <= in_prox;
      segments <= nxt == SHOW_NOTE ? in_note : nxt == SHOW_PROX ? in_prox : SEG_BLANK;
      prox_select <= (nxt == SHOW_PROX || nxt == BLANK_TO_PROX) ? DIGIT_PROX : DIGIT_NOTE;
      frame_done <= fd_nxt;
    end
endmodule

// File: tb/tb_neptune_display_sequencer.sv
// tb_neptune_display_sequencer: directed checks of alternation, buffering, dwell scaling, single mode, retarget and reset
module tb_neptune_display_sequencer;
  logic clk = 1'b0, rst = 1'b0, result_valid = 1'b0;
  logic display_single_enable = 1'b0, display_single_select = 1'b0;
  logic [2:0] clk_config = 3'd0;
  logic [6:0] note_segs = 7'h00, prox_segs = 7'h00, segments;
  logic prox_select, frame_done;
  int total = 0, bad = 0, n = 0;
  neptune_display_sequencer #(.DWELL_BASE(2), .DWELL_W(10), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .clk_config(clk_config), .note_segs(note_segs), .prox_segs(prox_segs),
    .result_valid(result_valid), .display_single_enable(display_single_enable),
    .display_single_select(display_single_select), .segments(segments),
    .prox_select(prox_select), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask
  task automatic run_to(input int k);
    while (n < k) step();
  endtask
  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @%0d: got %h want %h", tag, n, obs, exp);
    end
  endtask
  task automatic checkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @%0d: got %b want %b", tag, n, obs, exp);
    end
  endtask
  task automatic strobe(input logic [6:0] nv, input logic [6:0] pv);
    note_segs = nv;
    prox_segs = pv;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_segs", segments, 7'h00);
    checkb("rst_prox", prox_select, 1'b0);
    checkb("rst_fd", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      int p;
      step();
      p = (i - 2) % 12;
      check("idle_segs", segments, 7'h00);
      checkb("idle_prox", prox_select, i >= 2 && p >= 4 && p <= 9);
      checkb("idle_fd", frame_done, i >= 2 && p == 10);
    end
    run_to(33);
    strobe(7'h3F, 7'h06);
    check("buf_same_dwell", segments, 7'h00);
    run_to(37);
    check("buf_blank", segments, 7'h00);
    run_to(38);
    check("buf_note_first", segments, 7'h3F);
    checkb("buf_note_sel", prox_select, 1'b0);
    run_to(41);
    check("buf_note_last", segments, 7'h3F);
    run_to(42);
    check("buf_blank2", segments, 7'h00);
    checkb("buf_blank2_sel", prox_select, 1'b1);
    run_to(44);
    check("buf_prox", segments, 7'h06);
    run_to(47);
    check("buf_prox_last", segments, 7'h06);
    run_to(48);
    checkb("buf_fd", frame_done, 1'b1);
    clk_config = 3'd3;
    run_to(81);
    check("cfg3_note_end", segments, 7'h3F);
    run_to(82);
    check("cfg3_blank", segments, 7'h00);
    checkb("cfg3_blank_sel", prox_select, 1'b1);
    run_to(100);
    check("cfg3_prox_mid", segments, 7'h06);
    clk_config = 3'd0;
    run_to(115);
    check("cfg_change_late", segments, 7'h06);
    checkb("cfg_no_fd", frame_done, 1'b0);
    run_to(116);
    checkb("cfg3_fd", frame_done, 1'b1);
    run_to(117);
    checkb("cfg3_fd_pulse", frame_done, 1'b0);
    run_to(118);
    check("frame68_note", segments, 7'h3F);
    run_to(121);
    check("cfg0_note_last", segments, 7'h3F);
    run_to(122);
    check("cfg0_blank", segments, 7'h00);
    checkb("cfg0_blank_sel", prox_select, 1'b1);
    run_to(131);
    check("pre_single", segments, 7'h3F);
    display_single_enable = 1'b1;
    display_single_select = 1'b1;
    run_to(132);
    check("single_blank1", segments, 7'h00);
    checkb("single_blank1_sel", prox_select, 1'b1);
    run_to(133);
    check("single_blank2", segments, 7'h00);
    run_to(134);
    check("single_prox", segments, 7'h06);
    run_to(138);
    check("single_hold", segments, 7'h06);
    checkb("single_sel", prox_select, 1'b1);
    checkb("single_no_fd", frame_done, 1'b0);
    run_to(140);
    strobe(7'h5B, 7'h4F);
    run_to(142);
    check("single_reload", segments, 7'h4F);
    checkb("single_no_fd2", frame_done, 1'b0);
    run_to(145);
    check("single_pre_direct", segments, 7'h4F);
    strobe(7'h6D, 7'h7F);
    check("single_direct", segments, 7'h7F);
    checkb("single_sel2", prox_select, 1'b1);
    display_single_enable = 1'b0;
    run_to(149);
    check("release_cont", segments, 7'h7F);
    run_to(150);
    check("release_blank", segments, 7'h00);
    checkb("release_sel", prox_select, 1'b0);
    checkb("release_fd", frame_done, 1'b1);
    run_to(152);
    check("release_note", segments, 7'h6D);
    run_to(156);
    check("retgt_blank", segments, 7'h00);
    checkb("retgt_blank_sel", prox_select, 1'b1);
    display_single_enable = 1'b1;
    display_single_select = 1'b0;
    run_to(157);
    check("retgt_dark", segments, 7'h00);
    checkb("retgt_sel", prox_select, 1'b0);
    run_to(158);
    check("retgt_note", segments, 7'h6D);
    checkb("retgt_note_sel", prox_select, 1'b0);
    run_to(170);
    check("single_note_hold", segments, 7'h6D);
    checkb("single_note_fd", frame_done, 1'b0);
    strobe(7'h77, 7'h11);
    check("pend_uncommitted", segments, 7'h6D);
    rst = 1'b1;
    #1;
    check("async_segs", segments, 7'h00);
    checkb("async_prox", prox_select, 1'b0);
    checkb("async_fd", frame_done, 1'b0);
    display_single_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      check("post_rst_dark", segments, 7'h00);
    end
    strobe(7'h3F, 7'h06);
    for (int i = 0; i < 14 && segments !== 7'h3F; i++) step();
    check("post_rst_new", segments, 7'h3F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
